// File: rtl/palindrome_pkg.sv
// Shared types and the window match function for the serial palindrome detector.
// The match function takes a LEN_MAX-wide window plus a length, so any LEN up to LEN_MAX can use it.
package palindrome_pkg;

  localparam int LEN_MAX = 32;
  localparam int IDX_W   = $clog2(LEN_MAX);

  typedef enum logic {
    PAL_MODE_MIRROR = 1'b0,
    PAL_MODE_ANTI   = 1'b1
  } pal_mode_e;

  // Pairs (i, len-1-i) for i < len/2. For odd len the middle bit has no partner and is never compared.
  function automatic logic pal_match(input logic [LEN_MAX-1:0] window,
                                     input int                 len,
                                     input pal_mode_e          mode);
    logic             ok;
    logic [IDX_W-1:0] lo;
    logic [IDX_W-1:0] hi;
    ok = 1'b1;
    for (int i = 0; i < LEN_MAX / 2; i++) begin
      lo = IDX_W'(i);
      hi = IDX_W'(len - 1 - i);
      if (i < len / 2) begin
        if (mode == PAL_MODE_MIRROR) begin
          if (window[lo] != window[hi]) ok = 1'b0;
        end else begin
          if (window[lo] == window[hi]) ok = 1'b0;
        end
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/pal_window_shreg.sv
// History shift register and fill counter for the palindrome detector.
// The output window is {history, x_i}: bit 0 is the current bit and bit k is the k-th previous accepted bit.
module pal_window_shreg
  import palindrome_pkg::*;
#(
  parameter int LEN = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           x_i,
  input  logic           x_valid_i,
  input  logic           flush_i,
  output logic [LEN-1:0] window_o,
  output logic           full_o
);

  localparam int FILL_W = $clog2(LEN);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LEN - 1);

  logic [LEN-2:0]    hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  assign window_o = {hist_q, x_i};
  assign full_o   = (fill_q == FILL_LAST) && x_valid_i;

  // A flush drops any bit offered in the same cycle.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (flush_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (x_valid_i) begin
      hist_d = window_o[LEN-2:0];
      if (fill_q != FILL_LAST) fill_d = fill_q + FILL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/palindrome_nbit_det.sv
// Serial palindrome / anti-palindrome detector over overlapping LEN-bit windows, registered outputs.
// Optional saturating match counter on match_cnt_o when PALDET_COUNT_EN is defined.
module palindrome_nbit_det
  import palindrome_pkg::*;
#(
  parameter int LEN   = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x_i,
  input  logic             x_valid_i,
  input  logic             flush_i,
  input  logic             mode_i,
  output logic             det_valid_o,
  output logic             palindrome_o
`ifdef PALDET_COUNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt_o
`endif
);

  if (LEN < 2 || LEN > LEN_MAX) begin : g_len_check
    $error("palindrome_nbit_det: LEN must be within 2..32");
  end

  // Stream handshake: no backpressure; x_i is consumed on every cycle x_valid_i is 1 and flush_i is 0.
  logic [LEN-1:0]     window;
  logic               full;
  logic [LEN_MAX-1:0] window_ext;
  logic               match;
  logic               det_valid_q, det_valid_d;
  logic               palindrome_q, palindrome_d;

  pal_window_shreg #(.LEN(LEN)) u_shreg (
    .clk       (clk),
    .reset     (reset),
    .x_i       (x_i),
    .x_valid_i (x_valid_i),
    .flush_i   (flush_i),
    .window_o  (window),
    .full_o    (full)
  );

  assign window_ext = LEN_MAX'(window);
  assign match      = pal_match(window_ext, LEN, pal_mode_e'(mode_i));

  // palindrome_o keeps its last result across idle cycles; only flush or a new bit changes it.
  always_comb begin
    det_valid_d  = 1'b0;
    palindrome_d = palindrome_q;
    if (flush_i) begin
      palindrome_d = 1'b0;
    end else if (x_valid_i) begin
      det_valid_d  = 1'b1;
      palindrome_d = full && match;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      det_valid_q  <= 1'b0;
      palindrome_q <= 1'b0;
    end else begin
      det_valid_q  <= det_valid_d;
      palindrome_q <= palindrome_d;
    end
  end

  assign det_valid_o  = det_valid_q;
  assign palindrome_o = palindrome_q;

`ifdef PALDET_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts at the same edge that registers a match, so it tracks det_valid_o && palindrome_o.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else if (x_valid_i && full && match && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign match_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_palindrome_nbit_det.sv
// Bench for palindrome_nbit_det: six instances (LEN 2,3,4,5,8,32) share one input stream.
// Hand-computed vector table for the directed cases, plus a bit-history reference model checked every cycle.
module tb_palindrome_nbit_det;

  localparam int NI = 6;

  function automatic int len_of(input int k);
    case (k)
      0: return 2;
      1: return 3;
      2: return 4;
      3: return 5;
      4: return 8;
      default: return 32;
    endcase
  endfunction

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  logic x_i, x_valid_i, flush_i, mode_i;
  logic det_v [NI];
  logic pal_v [NI];
`ifdef PALDET_COUNT_EN
  logic [1:0] cnt_v [NI];
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    palindrome_nbit_det #(.LEN(len_of(g)), .CNT_W(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .x_i          (x_i),
      .x_valid_i    (x_valid_i),
      .flush_i      (flush_i),
      .mode_i       (mode_i),
      .det_valid_o  (det_v[g]),
      .palindrome_o (pal_v[g])
`ifdef PALDET_COUNT_EN
      ,
      .match_cnt_o  (cnt_v[g])
`endif
    );
  end

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;

  logic [31:0] m_hist [NI];
  int          m_fill [NI];
  logic        e_det  [NI];
  logic        e_pal  [NI];
  int          e_cnt  [NI];

  task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d len=%0d t=%0t got=%0h exp=%0h", name, k, len_of(k), $time, got, exp);
    end
  endtask

  function automatic logic bit_at(input logic [32:0] v, input int i);
    logic [5:0] idx;
    idx = i[5:0];
    return v[idx];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_hist[k] = '0;
      m_fill[k] = 0;
      e_det[k]  = 1'b0;
      e_pal[k]  = 1'b0;
      e_cnt[k]  = 0;
    end
  endtask

  // Expected outputs after the coming rising edge, from the queue of accepted bits.
  task automatic model_step(input logic x, input logic v, input logic f, input logic m);
    logic [32:0] w;
    logic        ok;
    int          len;
    for (int k = 0; k < NI; k++) begin
      len = len_of(k);
      if (f) begin
        m_hist[k] = '0;
        m_fill[k] = 0;
        e_det[k]  = 1'b0;
        e_pal[k]  = 1'b0;
        e_cnt[k]  = 0;
      end else if (v) begin
        w  = {m_hist[k], x};
        ok = (m_fill[k] >= len - 1);
        for (int i = 0; i < len / 2; i++) begin
          if (!m && (bit_at(w, i) != bit_at(w, len - 1 - i))) ok = 1'b0;
          if (m && (bit_at(w, i) == bit_at(w, len - 1 - i))) ok = 1'b0;
        end
        e_det[k] = 1'b1;
        e_pal[k] = ok;
        if (ok && e_cnt[k] < 3) e_cnt[k]++;
        m_hist[k] = {m_hist[k][30:0], x};
        m_fill[k]++;
      end else begin
        e_det[k] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      chk("model_det", k, 32'(det_v[k]), 32'(e_det[k]));
      chk("model_pal", k, 32'(pal_v[k]), 32'(e_pal[k]));
`ifdef PALDET_COUNT_EN
      chk("model_cnt", k, 32'(cnt_v[k]), 32'(e_cnt[k]));
`endif
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic x, input logic v, input logic f, input logic m);
    @(negedge clk);
    x_i       = x;
    x_valid_i = v;
    flush_i   = f;
    mode_i    = m;
    model_step(x, v, f, m);
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Asserted away from any clock edge; outputs must clear without waiting for a clock.
  task automatic apply_reset();
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    x_valid_i = 1'b0;
    flush_i   = 1'b0;
    reset     = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic x;
    logic v;
    logic f;
    logic m;
    int   inst;
    logic e_det;
    logic e_pal;
    int   e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic x, input logic v, input logic f, input logic m, input int inst,
                     input logic ed, input logic ep, input int ec);
    vec_t r;
    r.x = x; r.v = v; r.f = f; r.m = m; r.inst = inst;
    r.e_det = ed; r.e_pal = ep; r.e_cnt = ec;
    vecs.push_back(r);
  endtask

  task automatic build_table();
    // T1: LEN=5 mirror, 1,0,1,0,1,1
    add(0, 0, 1, 0, 3, 0, 0, -1);
    add(1, 1, 0, 0, 3, 1, 0, -1);
    add(0, 1, 0, 0, 3, 1, 0, -1);
    add(1, 1, 0, 0, 3, 1, 0, -1);
    add(0, 1, 0, 0, 3, 1, 0, -1);
    add(1, 1, 0, 0, 3, 1, 1, -1);
    add(1, 1, 0, 0, 3, 1, 0, -1);
    // T2: LEN=4 anti, 1,1,0,0 matches; 1,0,0,1 does not
    add(0, 0, 1, 1, 2, 0, 0, -1);
    add(1, 1, 0, 1, 2, 1, 0, -1);
    add(1, 1, 0, 1, 2, 1, 0, -1);
    add(0, 1, 0, 1, 2, 1, 0, -1);
    add(0, 1, 0, 1, 2, 1, 1, -1);
    add(0, 0, 1, 1, 2, 0, 0, -1);
    add(1, 1, 0, 1, 2, 1, 0, -1);
    add(0, 1, 0, 1, 2, 1, 0, -1);
    add(0, 1, 0, 1, 2, 1, 0, -1);
    add(1, 1, 0, 1, 2, 1, 0, -1);
    // T3: LEN=3, gap of 3 idle cycles inside the window, then hold after a match
    add(0, 0, 1, 0, 1, 0, 0, -1);
    add(1, 1, 0, 0, 1, 1, 0, -1);
    add(0, 1, 0, 0, 1, 1, 0, -1);
    add(1, 0, 0, 0, 1, 0, 0, -1);
    add(0, 0, 0, 0, 1, 0, 0, -1);
    add(1, 0, 0, 0, 1, 0, 0, -1);
    add(1, 1, 0, 0, 1, 1, 1, -1);
    add(0, 0, 0, 0, 1, 0, 1, -1);
    // LEN=3 mode switch mid-stream: 010 fails anti, 100 passes anti (middle ignored)
    add(0, 1, 0, 1, 1, 1, 0, -1);
    add(0, 1, 0, 1, 1, 1, 1, -1);
    // T4: LEN=5, flush with a simultaneous valid bit drops it
    add(0, 0, 1, 0, 3, 0, 0, -1);
    add(1, 1, 0, 0, 3, 1, 0, -1);
    add(1, 1, 0, 0, 3, 1, 0, -1);
    add(1, 1, 0, 0, 3, 1, 0, -1);
    add(1, 1, 0, 0, 3, 1, 0, -1);
    add(1, 1, 1, 0, 3, 0, 0, -1);
    add(1, 1, 0, 0, 3, 1, 0, -1);
    add(0, 1, 0, 0, 3, 1, 0, -1);
    add(1, 1, 0, 0, 3, 1, 0, -1);
    add(0, 1, 0, 0, 3, 1, 0, -1);
    add(1, 1, 0, 0, 3, 1, 1, -1);
    // T5: LEN=2, constant ones, counter saturates at 3
    add(0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, 0, 0);
    add(1, 1, 0, 0, 0, 1, 1, 1);
    add(1, 1, 0, 0, 0, 1, 1, 2);
    add(1, 1, 0, 0, 0, 1, 1, 3);
    add(1, 1, 0, 0, 0, 1, 1, 3);
    add(1, 1, 0, 0, 0, 1, 1, 3);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t r;
    int   pat;
    logic xb;
    reset     = 1'b1;
    x_i       = 1'b0;
    x_valid_i = 1'b0;
    flush_i   = 1'b0;
    mode_i    = 1'b0;
    #3;
    apply_reset();

    build_table();
    foreach (vecs[n]) begin
      r = vecs[n];
      drive(r.x, r.v, r.f, r.m);
      chk("vec_det", r.inst, 32'(det_v[r.inst]), 32'(r.e_det));
      chk("vec_pal", r.inst, 32'(pal_v[r.inst]), 32'(r.e_pal));
`ifdef PALDET_COUNT_EN
      if (r.e_cnt >= 0) chk("vec_cnt", r.inst, 32'(cnt_v[r.inst]), 32'(r.e_cnt));
`endif
    end

    // Mid-stream asynchronous reset, then the first window needs LEN fresh bits again
    #1;
    apply_reset();
    chk("rst_det", 0, 32'(det_v[0]), 32'(0));
    chk("rst_pal", 0, 32'(pal_v[0]), 32'(0));
    drive(1, 1, 0, 0);
    chk("post_rst_first", 0, 32'(pal_v[0]), 32'(0));
    drive(1, 1, 0, 0);
    chk("post_rst_second", 0, 32'(pal_v[0]), 32'(1));

    // T6: mixed random / constant / alternating blocks so long windows also match
    xb = 1'b0;
    for (int blk = 0; blk < 60; blk++) begin
      pat = $urandom_range(0, 2);
      for (int c = 0; c < 50; c++) begin
        case (pat)
          0: xb = 1'($urandom_range(0, 1));
          1: xb = xb;
          default: xb = ~xb;
        endcase
        drive(xb, ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0),
              1'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
